aes_inv_key_sched: RTL and testbench

//  Decrypt-side round-key source for the AES-128 datapath. Accepts one cipher key and expands it into 11 round keys, one round per cycle.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/aes_sbox.sv | 9 +
 rtl/aes_inv_key_sched.sv | 114 +++++++++++
 tb/tb_aes_inv_key_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM encoding and byte helpers for the key-schedule slice.
package aes_pkg;
  localparam int AES_NR = 10;
  localparam int AES_KW = 128;

  typedef enum logic [1:0] {IDLE, EXPAND, PLAY} state_t;

  // Forward S-box, element 0 in the leftmost byte.
  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Key words are columns; the inverse datapath wants row-major state bytes.
  function automatic logic [AES_KW-1:0] transpose(input logic [AES_KW-1:0] k);
    transpose = '0;
    for (int j = 0; j < 16; j++)
      transpose[j*8 +: 8] = k[((j % 4) * 4 + j / 4) * 8 +: 8];
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX_TBL[a];
endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key expansion into an 11-entry register file, played back round 10 -> 0
// over a valid/ready handshake in state byte order.
module aes_inv_key_sched
  import aes_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ARRAY_SIZE = 16,
  parameter int NR         = AES_NR
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [WORD_SIZE*ARRAY_SIZE-1:0] key_in,
  input  logic                            key_valid,
  output logic                            key_ready,
  input  logic                            replay,
  output logic [WORD_SIZE*ARRAY_SIZE-1:0] rk_out,
  output logic [3:0]                      rk_round,
  output logic                            rk_valid,
  input  logic                            rk_ready,
  output logic                            done
);
  localparam int KW = WORD_SIZE * ARRAY_SIZE;

  state_t        state;
  logic [3:0]    cnt;
  logic          keys_stored;
  logic [KW-1:0] rk [0:NR];
  logic [KW-1:0] prev, next_key;
  logic [3:0][7:0] sb_in, sb_out;

  // rk[cnt-1] serves both as expansion source and as the next key to play back.
  always_comb begin
    prev = '0;
    for (int i = 0; i <= NR; i++)
      if (cnt - 4'd1 == 4'(i)) prev = rk[i];
  end

  // SubWord(RotWord(w3)): w3 = bytes 12..15, rotated to 13,14,15,12.
  assign sb_in = {prev[12*8 +: 8], prev[15*8 +: 8], prev[14*8 +: 8], prev[13*8 +: 8]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[g]), .y(sb_out[g]));
  end

  always_comb begin
    next_key = '0;
    for (int j = 0; j < 4; j++) begin
      next_key[j*8 +: 8] = prev[j*8 +: 8] ^ sb_out[j] ^ ((j == 0) ? rcon(cnt) : 8'h00);
      for (int k = 1; k < 4; k++)
        next_key[(4*k+j)*8 +: 8] = prev[(4*k+j)*8 +: 8] ^ next_key[(4*(k-1)+j)*8 +: 8];
    end
  end

  assign key_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      keys_stored <= 1'b0;
      rk_out      <= '0;
      rk_round    <= '0;
      rk_valid    <= 1'b0;
      done        <= 1'b0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            rk[0] <= key_in;
            cnt   <= 4'd1;
            state <= EXPAND;
          end else if (replay && keys_stored) begin
            cnt      <= 4'(NR);
            state    <= PLAY;
            rk_valid <= 1'b1;
            rk_round <= 4'(NR);
            rk_out   <= transpose(rk[NR]);
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NR; i++)
            if (cnt == 4'(i)) rk[i] <= next_key;
          if (cnt == 4'(NR)) begin
            keys_stored <= 1'b1;
            state       <= PLAY;
            rk_valid    <= 1'b1;
            rk_round    <= 4'(NR);
            rk_out      <= transpose(next_key);
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PLAY: begin
          if (rk_ready) begin
            if (cnt != 4'd0) begin
              cnt      <= cnt - 4'd1;
              rk_round <= cnt - 4'd1;
              rk_out   <= transpose(prev);
            end else begin
              state    <= IDLE;
              rk_valid <= 1'b0;
              rk_round <= '0;
              rk_out   <= '0;
              done     <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed/random bench for aes_inv_key_sched against a word-level FIPS-197 key expansion model.
module tb_aes_inv_key_sched;
  logic         clk = 1'b0, rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_valid = 1'b0, replay = 1'b0, rk_ready = 1'b0;
  logic         key_ready, rk_valid, done;
  logic [127:0] rk_out;
  logic [3:0]   rk_round;

  int errs = 0, checks = 0;
  logic [7:0]   sb [256];
  logic [127:0] mk [11];

  aes_inv_key_sched dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .replay(replay), .rk_out(rk_out), .rk_round(rk_round), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00, s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  // FIPS hex string (first byte leftmost) -> bus with byte 0 at [7:0].
  function automatic logic [127:0] hx(input logic [127:0] h);
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = h[127-8*i -: 8];
    return r;
  endfunction

  // State matrix: row r, column c holds key byte 4c+r; output is row-major.
  function automatic logic [127:0] xp(input logic [127:0] k);
    logic [127:0] r = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        r[(4*row+col)*8 +: 8] = k[(4*col+row)*8 +: 8];
    return r;
  endfunction

  task automatic expand_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++)
      w[i] = {key[(4*i)*8 +: 8], key[(4*i+1)*8 +: 8], key[(4*i+2)*8 +: 8], key[(4*i+3)*8 +: 8]};
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      for (int k = 0; k < 4; k++)
        for (int j = 0; j < 4; j++)
          mk[r][(4*k+j)*8 +: 8] = w[4*r+k][31-8*j -: 8];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Call right after the accept edge; returns edges from accept to rk_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (!rk_valid && n < 40) begin tick(); n++; end
  endtask

  task automatic load_key(input logic [127:0] k, output int n);
    key_in = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    wait_valid(n);
  endtask

  // mode 0: always ready; 1: random ready plus a 20-cycle stall at round 5;
  // 2: always ready with a foreign key_valid pulse at round 7.
  task automatic play(input string tag, input int mode);
    int r = 10, guard = 0, hs = 0, stall = 0;
    logic rdy;
    while (r >= 0 && guard < 2000) begin
      chk({tag, "_valid"}, 128'(rk_valid), 128'(1));
      chk({tag, "_round"}, 128'(rk_round), 128'(r));
      chk({tag, "_key"}, rk_out, xp(mk[r]));
      rdy = 1'b1;
      key_valid = 1'b0;
      if (mode == 1) begin
        if (r == 5 && stall < 20) begin rdy = 1'b0; stall++; end
        else rdy = 1'($urandom_range(0, 1));
      end else if (mode == 2 && r == 7) begin
        key_valid = 1'b1; key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      rk_ready = rdy;
      tick();
      guard++;
      if (rdy) begin r--; hs++; end
    end
    key_valid = 1'b0;
    rk_ready = 1'b0;
    chk({tag, "_handshakes"}, 128'(hs), 128'(11));
    chk({tag, "_end_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(1));
    chk({tag, "_end_ready"}, 128'(key_ready), 128'(1));
    tick();
    chk({tag, "_done_pulse"}, 128'(done), 128'(0));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_key_ready"}, 128'(key_ready), 128'(1));
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_rk_out"}, rk_out, 128'(0));
    chk({tag, "_rk_round"}, 128'(rk_round), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
  endtask

  initial begin
    int n;
    logic [127:0] k;
    build_sbox();
    tick(); tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    // FIPS-197 appendix key
    k = hx(128'h2b7e151628aed2a6abf7158809cf4f3c);
    expand_model(k);
    load_key(k, n);
    chk("t1_latency", 128'(n), 128'(11));
    chk("t1_r10_bytes", 128'(rk_out[31:0]), 128'(32'hb6e1c9d0));
    chk("t1_r10_full", rk_out, xp(hx(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)));
    chk("t1_r0_model", 128'(xp(mk[0])), 128'(xp(k)));
    play("t1", 0);

    k = hx(128'h000102030405060708090a0b0c0d0e0f);
    expand_model(k);
    load_key(k, n);
    chk("t2_latency", 128'(n), 128'(11));
    chk("t2_r10_full", rk_out, xp(hx(128'h13111d7fe3944a17f307a78b4d2b30c5)));
    play("t2", 0);

    k = {$urandom, $urandom, $urandom, $urandom};
    expand_model(k);
    load_key(k, n);
    chk("t3_latency", 128'(n), 128'(11));
    play("t3", 1);

    // replay of stored keys: PLAY straight from IDLE
    replay = 1'b1;
    tick();
    replay = 1'b0;
    chk("t4_valid_next", 128'(rk_valid), 128'(1));
    play("t4", 0);

    // reset during EXPAND with cnt=5
    k = {$urandom, $urandom, $urandom, $urandom};
    expand_model(k);
    key_in = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (4) tick();
    chk("t5a_busy", 128'(key_ready), 128'(0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("t5a");
    replay = 1'b1;
    tick();
    replay = 1'b0;
    chk("t5a_replay_ignored", 128'(rk_valid), 128'(0));
    tick();
    chk("t5a_replay_ignored2", 128'(rk_valid), 128'(0));

    // reset during PLAY at round 4
    load_key(k, n);
    chk("t5b_latency", 128'(n), 128'(11));
    rk_ready = 1'b1;
    n = 0;
    while (rk_round != 4'd4 && n < 20) begin tick(); n++; end
    rk_ready = 1'b0;
    chk("t5b_round4", 128'(rk_round), 128'(4));
    chk("t5b_key4", rk_out, xp(mk[4]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("t5b");
    replay = 1'b1;
    tick();
    replay = 1'b0;
    chk("t5b_replay_ignored", 128'(rk_valid), 128'(0));
    tick();

    // key_valid wins over replay; foreign key during PLAY ignored
    k = {$urandom, $urandom, $urandom, $urandom};
    expand_model(k);
    load_key(k, n);
    play("t6a", 0);
    k = {$urandom, $urandom, $urandom, $urandom};
    expand_model(k);
    key_in = k; key_valid = 1'b1; replay = 1'b1;
    tick();
    key_valid = 1'b0; replay = 1'b0;
    chk("t6_expanding", 128'(key_ready), 128'(0));
    chk("t6_not_playing", 128'(rk_valid), 128'(0));
    wait_valid(n);
    chk("t6_latency", 128'(n), 128'(11));
    play("t6", 2);
    replay = 1'b1;
    tick();
    replay = 1'b0;
    play("t6r", 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
